cache_arbiter: RTL and testbench



---
 rtl/cache_arbiter.sv | 132 +++++++++++++
 tb/tb_cache_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cacheline-wide memory port between the icache and the dcache.
// Define CACHE_ARB_ROUND_ROBIN_EN to alternate winners on conflicts; the default gives the dcache priority.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  // state  | meaning
  // IDLE   | sampling requests
  // I_BUSY | icache line read at memory
  // D_BUSY | dcache read or writeback at memory
  // DONE   | one-cycle resp to the owner
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              op_write_q, op_write_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              d_req;
  logic              pick_dcache;
  logic              busy;

  assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  // last_grant: 1 = dcache was granted most recently
  logic last_grant_q, last_grant_d;
  assign pick_dcache = d_req & (~i_read | ~last_grant_q);
`else
  assign pick_dcache = d_req;
`endif

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_dcache) begin
          state_d    = D_BUSY;
          op_write_d = d_write;
          addr_d     = d_addr;
          wdata_d    = d_wdata;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b1;
`endif
        end else if (i_read) begin
          state_d    = I_BUSY;
          op_write_d = 1'b0;
          addr_d     = i_addr;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          if (!op_write_q) line_d = mem_rdata;
          owner_d = (state_q == D_BUSY);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Strobes decode straight from the state flop so reset drops them without a clock edge.
  assign busy      = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign mem_read  = busy & ~op_write_q;
  assign mem_write = busy & op_write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_resp    = (state_q == DONE) & ~owner_q;
  assign d_resp    = (state_q == DONE) & owner_q;
  assign i_rdata   = line_q;
  assign d_rdata   = line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read, d_read, d_write, mem_resp;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [LINE_W-1:0] d_wdata, mem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_resp, d_resp, mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic note_fail(input string name, input string act, input string exp);
    n_fail++;
    if (n_fail <= 40) $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) note_fail(name, $sformatf("%b", act), $sformatf("%b", exp));
  endtask

  task automatic chka(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
    n_cmp++;
    if (act !== exp) note_fail(name, $sformatf("%h", act), $sformatf("%h", exp));
  endtask

  task automatic chkl(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) note_fail(name, $sformatf("%h", act), $sformatf("%h", exp));
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Winner of an IDLE grant decision: 1 = dcache.
  function automatic logic pick_d(input logic i_req, input logic d_req, input logic last_d);
    if (!d_req) return 1'b0;
    if (!i_req) return 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction

  // Transaction-level model: phase 0 = nothing in flight, 1 = at memory, 2 = responding.
  int                m_phase;
  logic              m_own_d, m_wr, m_last_d, m_pick;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata, m_line;
  logic              exp_read, exp_write, exp_iresp, exp_dresp;

  assign m_pick    = pick_d(i_read, d_read | d_write, m_last_d);
  assign exp_read  = (m_phase == 1) && !m_wr;
  assign exp_write = (m_phase == 1) && m_wr;
  assign exp_iresp = (m_phase == 2) && !m_own_d;
  assign exp_dresp = (m_phase == 2) && m_own_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase  <= 0;
      m_own_d  <= 1'b0;
      m_wr     <= 1'b0;
      m_last_d <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_line   <= '0;
    end else begin
      case (m_phase)
        0: if (i_read || d_read || d_write) begin
             m_phase  <= 1;
             m_own_d  <= m_pick;
             m_last_d <= m_pick;
             m_wr     <= m_pick && d_write;
             m_addr   <= m_pick ? d_addr : i_addr;
             m_wdata  <= d_wdata;
           end
        1: if (mem_resp) begin
             if (!m_wr) m_line <= mem_rdata;
             m_phase <= 2;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk1("mdl_mem_read", mem_read, exp_read);
      chk1("mdl_mem_write", mem_write, exp_write);
      chk1("mdl_i_resp", i_resp, exp_iresp);
      chk1("mdl_d_resp", d_resp, exp_dresp);
      chkl("mdl_i_rdata", i_rdata, m_line);
      chkl("mdl_d_rdata", d_rdata, m_line);
      if (m_phase == 1) chka("mdl_mem_addr", mem_addr, m_addr);
      if (m_phase == 1 && m_wr) chkl("mdl_mem_wdata", mem_wdata, m_wdata);
    end
  end

  // Two requests raised together with immediate memory responses; dcache expected first.
  task automatic conflict_pair(input logic [ADDR_W-1:0] ia, input logic [ADDR_W-1:0] da,
                               input logic [LINE_W-1:0] r1, input logic [LINE_W-1:0] r2);
    i_read = 1'b1; i_addr = ia; d_read = 1'b1; d_addr = da; mem_rdata = r1;
    @(negedge clk);
    chk1("pair_first_read", mem_read, 1'b1);
    chka("pair_first_addr", mem_addr, da);
    mem_resp = 1'b1;
    @(negedge clk);
    chk1("pair_d_resp", d_resp, 1'b1);
    chk1("pair_i_resp_early", i_resp, 1'b0);
    chkl("pair_d_rdata", d_rdata, r1);
    mem_resp = 1'b0; d_read = 1'b0; mem_rdata = r2;
    @(negedge clk);
    chk1("pair_idle_gap", mem_read, 1'b0);
    @(negedge clk);
    chk1("pair_second_read", mem_read, 1'b1);
    chka("pair_second_addr", mem_addr, ia);
    mem_resp = 1'b1;
    @(negedge clk);
    chk1("pair_i_resp", i_resp, 1'b1);
    chkl("pair_i_rdata", i_rdata, r2);
    mem_resp = 1'b0; i_read = 1'b0;
    @(negedge clk);
    chk1("pair_i_resp_once", i_resp, 1'b0);
  endtask

  initial begin
    logic [LINE_W-1:0] pat_a5, pat_5a, pat_beef, r3;
    int rd_cycles;
    bit i_out, d_out;
    int mem_wait;

    pat_a5 = {(LINE_W/8){8'hA5}};
    pat_5a = {(LINE_W/8){8'h5A}};
    pat_beef = {(LINE_W/32){32'hDEAD_BEEF}};
    r3 = {(LINE_W/32){32'h3333_CCCC}};
    rst_n = 1'b0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; mem_resp = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_i_resp", i_resp, 1'b0);
    chk1("rst_d_resp", d_resp, 1'b0);
    chka("rst_mem_addr", mem_addr, '0);
    chkl("rst_mem_wdata", mem_wdata, '0);
    chkl("rst_i_rdata", i_rdata, '0);
    chkl("rst_d_rdata", d_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // icache read, memory answers in the third strobe cycle
    i_read = 1'b1; i_addr = 32'h0000_0040; mem_rdata = pat_a5;
    rd_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (mem_read) rd_cycles++;
      chka("t1_mem_addr", mem_addr, 32'h0000_0040);
      mem_resp = (c == 3);
    end
    @(negedge clk);
    chk1("t1_read_cycles", (rd_cycles == 3), 1'b1);
    chk1("t1_i_resp", i_resp, 1'b1);
    chk1("t1_d_resp", d_resp, 1'b0);
    chkl("t1_i_rdata", i_rdata, pat_a5);
    chk1("t1_done_no_strobe", mem_read, 1'b0);
    i_read = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    chk1("t1_i_resp_once", i_resp, 1'b0);

    // dcache writeback; the returned line must not overwrite the buffer
    d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = pat_beef; mem_rdata = pat_5a;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk1("t2_mem_write", mem_write, 1'b1);
      chk1("t2_mem_read", mem_read, 1'b0);
      chka("t2_mem_addr", mem_addr, 32'h0000_1000);
      chkl("t2_mem_wdata", mem_wdata, pat_beef);
      mem_resp = (c == 2);
    end
    @(negedge clk);
    chk1("t2_d_resp", d_resp, 1'b1);
    chk1("t2_i_resp", i_resp, 1'b0);
    chkl("t2_line_kept", d_rdata, pat_a5);
    d_write = 1'b0; mem_resp = 1'b0;
    @(negedge clk);
    chk1("t2_d_resp_once", d_resp, 1'b0);

    // simultaneous requests, twice
    conflict_pair(32'h0000_0200, 32'h0000_0300, {(LINE_W/32){32'h1111_1111}}, {(LINE_W/32){32'h2222_2222}});
    conflict_pair(32'h0000_0400, 32'h0000_0500, {(LINE_W/32){32'h4444_4444}}, {(LINE_W/32){32'h5555_5555}});

    // icache drops its request after the grant
    i_read = 1'b1; i_addr = 32'h0000_0080;
    @(negedge clk);
    chk1("t5_granted", mem_read, 1'b1);
    i_read = 1'b0;
    @(negedge clk);
    chk1("t5_still_reading", mem_read, 1'b1);
    mem_resp = 1'b1; mem_rdata = r3;
    @(negedge clk);
    chk1("t5_i_resp", i_resp, 1'b1);
    chkl("t5_i_rdata", i_rdata, r3);
    mem_resp = 1'b0;
    @(negedge clk);
    chk1("t5_i_resp_once", i_resp, 1'b0);
    chk1("t5_idle", mem_read, 1'b0);

    // reset during a writeback
    d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = pat_beef;
    @(negedge clk);
    chk1("t4_mem_write", mem_write, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk1("t4_async_drop", mem_write, 1'b0);
    d_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk1("t4_no_d_resp", d_resp, 1'b0);
      chk1("t4_no_write", mem_write, 1'b0);
    end
    chkl("t4_line_cleared", i_rdata, '0);

    // randomized traffic
    i_out = 1'b0; d_out = 1'b0; mem_wait = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      mem_rdata = rand_line();
      if (m_phase == 1) begin
        if (mem_wait == 0) mem_resp = 1'b1;
        else mem_wait--;
      end else begin
        mem_resp = 1'b0;
        mem_wait = $urandom_range(0, 3);
      end

      if (i_out && exp_iresp) begin
        i_out = 1'b0; i_read = 1'b0;
      end else if (!i_out && $urandom_range(0, 2) == 0) begin
        i_out = 1'b1; i_read = 1'b1; i_addr = $urandom & 32'hFFFF_FFE0;
      end else if (i_out && i_read && m_phase == 1 && !m_own_d && $urandom_range(0, 15) == 0) begin
        i_read = 1'b0;
      end

      if (d_out && exp_dresp) begin
        d_out = 1'b0; d_read = 1'b0; d_write = 1'b0;
      end else if (!d_out && $urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 7);
        d_out = 1'b1;
        d_write = (op <= 3);
        d_read = (op == 0) || (op >= 4);
        d_addr = $urandom & 32'hFFFF_FFE0;
        d_wdata = rand_line();
      end else if (d_out && (d_read || d_write) && m_phase == 1 && m_own_d && $urandom_range(0, 15) == 0) begin
        d_read = 1'b0; d_write = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
